// File: rtl/fp_result_drain.sv
// rtl/fp_result_drain.sv - per-lane result FIFOs drained round-robin onto one tagged valid/ready stream
// Lanes cannot be stalled: a write into a full FIFO is dropped and counted.
module fp_result_drain #(
  parameter int INPUTS       = 8,
  parameter int BIT_VEC_SIZE = 128,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_ZERO    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUTS*BIT_VEC_SIZE-1:0]   in,
  input  logic [INPUTS-1:0]                valid_in,
  output logic [BIT_VEC_SIZE-1:0]          out_data,
  output logic [$clog2(INPUTS)-1:0]        out_lane,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             clr_stats,
  output logic                             overflow,
  output logic [15:0]                      drop_count,
  output logic                             idle
);

  localparam int LW = $clog2(INPUTS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [BIT_VEC_SIZE-1:0] r_mem [INPUTS][FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr [INPUTS];
  logic [PW-1:0]           r_rd_ptr [INPUTS];
  logic [CW-1:0]           r_count  [INPUTS];
  logic [LW-1:0]           r_rr_ptr;
  logic [LW-1:0]           r_out_lane;
  logic [BIT_VEC_SIZE-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_overflow;
  logic [15:0]             r_drop_count;

  logic [INPUTS-1:0] w_nonempty;
  logic [INPUTS-1:0] w_req;
  logic [INPUTS-1:0] w_acc;
  logic [INPUTS-1:0] w_drop;
  logic [INPUTS-1:0] w_pop;
  logic [LW-1:0]     w_idx;
  logic [LW-1:0]     w_grant;
  logic              w_found;
  logic              w_load;
  logic [16:0]       w_ndrop;
  logic [16:0]       w_drop_sum;

  // Round-robin pick of the first non-empty lane starting at r_rr_ptr
  always_comb begin
    w_nonempty = '0;
    w_idx      = '0;
    w_grant    = '0;
    w_found    = 1'b0;
    w_pop      = '0;
    for (int k = 0; k < INPUTS; k++) begin
      w_nonempty[k] = (r_count[k] != '0);
    end
    for (int i = 0; i < INPUTS; i++) begin
      w_idx = r_rr_ptr + LW'(i);
      if (!w_found && w_nonempty[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
    w_load = !r_out_valid || out_ready;
    if (w_load && w_found) begin
      w_pop[w_grant] = 1'b1;
    end
  end

  // A pop in the same cycle frees a slot, so a full lane being drained still accepts
  always_comb begin
    w_req  = '0;
    w_acc  = '0;
    w_drop = '0;
    for (int k = 0; k < INPUTS; k++) begin
      w_req[k]  = valid_in[k] &&
                  !((DROP_ZERO != 0) && (in[k*BIT_VEC_SIZE +: BIT_VEC_SIZE] == '0));
      w_acc[k]  = w_req[k] && ((r_count[k] != FULL) || w_pop[k]);
      w_drop[k] = w_req[k] && !w_acc[k];
    end
  end

  always_comb begin
    w_ndrop = '0;
    for (int k = 0; k < INPUTS; k++) begin
      w_ndrop = w_ndrop + 17'(w_drop[k]);
    end
    w_drop_sum = {1'b0, r_drop_count} + w_ndrop;
  end

  // Storage is not reset; validity is carried entirely by the counts
  always_ff @(posedge clk) begin
    for (int k = 0; k < INPUTS; k++) begin
      if (w_acc[k]) begin
        r_mem[k][r_wr_ptr[k]] <= in[k*BIT_VEC_SIZE +: BIT_VEC_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < INPUTS; k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < INPUTS; k++) begin
        if (w_acc[k]) begin
          r_wr_ptr[k] <= r_wr_ptr[k] + 1'b1;
        end
        if (w_pop[k]) begin
          r_rd_ptr[k] <= r_rd_ptr[k] + 1'b1;
        end
        r_count[k] <= r_count[k] + CW'(w_acc[k]) - CW'(w_pop[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[w_grant][r_rd_ptr[w_grant]];
        r_out_lane  <= w_grant;
        r_rr_ptr    <= w_grant + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clr_stats) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (|w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign out_data   = r_out_data;
  assign out_lane   = r_out_lane;
  assign out_valid  = r_out_valid;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign idle       = ~|w_nonempty && !r_out_valid;

endmodule

// File: tb/tb_fp_result_drain.sv
// tb/tb_fp_result_drain.sv - table-driven and directed checks for fp_result_drain
module tb_fp_result_drain;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1023:0] in_bus = '0;
  logic [7:0]   valid_in = '0;
  logic         out_ready = 1'b1;
  logic         clr_stats = 1'b0;

  logic [127:0] out_data, nz_data;
  logic [2:0]   out_lane, nz_lane;
  logic         out_valid, nz_valid;
  logic         overflow, nz_overflow;
  logic [15:0]  drop_count, nz_drop_count;
  logic         idle, nz_idle;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_result_drain dut (
    .clk(clk), .rst(rst), .in(in_bus), .valid_in(valid_in),
    .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready),
    .clr_stats(clr_stats), .overflow(overflow), .drop_count(drop_count), .idle(idle)
  );

  fp_result_drain #(.DROP_ZERO(0)) dut_nz (
    .clk(clk), .rst(rst), .in(in_bus), .valid_in(valid_in),
    .out_data(nz_data), .out_lane(nz_lane), .out_valid(nz_valid), .out_ready(out_ready),
    .clr_stats(clr_stats), .overflow(nz_overflow), .drop_count(nz_drop_count), .idle(nz_idle)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  vmask;
    logic [31:0] dval;
    logic        inc;
    logic        e_valid;
    logic [2:0]  e_lane;
    logic [31:0] e_data;
    logic        e_idle;
    logic        nz_valid;
    logic [31:0] nz_data;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Selected lanes carry dval (+lane index when inc); idle lanes carry nonzero junk
  task automatic drive(input logic [7:0] m, input logic [31:0] dv, input logic inc);
    for (int k = 0; k < 8; k++) begin
      if (m[k]) in_bus[k*128 +: 128] = 128'(dv) + (inc ? 128'(k) : 128'd0);
      else      in_bus[k*128 +: 128] = 128'(32'hDEAD0000 + k);
    end
    valid_in = m;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [127:0] got [16];
  int ngot;
  int stale;

  initial begin
    // rst vmask dval inc | valid lane data idle | nz_valid nz_data
    tbl[0]  = '{1'b1, 8'h00, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 8'h08, 32'd5, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 3'd3, 32'd5, 1'b0, 1'b1, 32'd5};
    tbl[3]  = '{1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 3'd3, 32'd5, 1'b1, 1'b0, 32'd5};
    tbl[4]  = '{1'b1, 8'h00, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    tbl[5]  = '{1'b0, 8'hFF, 32'd1, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      tbl[6+i] = '{1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 3'(i), 32'(i+1), 1'b0, 1'b1, 32'(i+1)};
    end
    tbl[14] = '{1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 3'd7, 32'd8, 1'b1, 1'b0, 32'd8};
    tbl[15] = '{1'b0, 8'h04, 32'd0, 1'b0, 1'b0, 3'd7, 32'd8, 1'b1, 1'b0, 32'd8};
    tbl[16] = '{1'b0, 8'h04, 32'd1, 1'b0, 1'b0, 3'd7, 32'd8, 1'b0, 1'b1, 32'd0};
    tbl[17] = '{1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 3'd2, 32'd1, 1'b0, 1'b1, 32'd1};
    tbl[18] = '{1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 3'd2, 32'd1, 1'b1, 1'b0, 32'd1};

    #1;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].vmask, tbl[i].dval, tbl[i].inc);
      tick();
      chk($sformatf("row%0d out_valid", i), 128'(out_valid), 128'(tbl[i].e_valid));
      chk($sformatf("row%0d out_lane", i), 128'(out_lane), 128'(tbl[i].e_lane));
      chk($sformatf("row%0d out_data", i), out_data, 128'(tbl[i].e_data));
      chk($sformatf("row%0d idle", i), 128'(idle), 128'(tbl[i].e_idle));
      chk($sformatf("row%0d drop_count", i), 128'(drop_count), 128'd0);
      chk($sformatf("row%0d nz_valid", i), 128'(nz_valid), 128'(tbl[i].nz_valid));
      chk($sformatf("row%0d nz_data", i), nz_data, 128'(tbl[i].nz_data));
    end
    rst = 1'b0;

    // Backpressure: six vectors into lane 0 with the drain stalled
    drive(8'h00, 0, 0);
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      drive(8'h01, 32'hA + j, 0);
      tick();
    end
    drive(8'h00, 0, 0);
    tick();
    chk("bp out_valid", 128'(out_valid), 128'd1);
    chk("bp held data", out_data, 128'hA);
    chk("bp overflow", 128'(overflow), 128'd1);
    chk("bp drop_count", 128'(drop_count), 128'd1);
    out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid && out_ready && ngot < 16) begin
        got[ngot] = out_data;
        ngot++;
      end
      tick();
    end
    chk("bp emitted count", 128'(ngot), 128'd5);
    for (int j = 0; j < 5; j++) begin
      if (j < ngot) chk($sformatf("bp order %0d", j), got[j], 128'(32'hA + j));
    end
    chk("bp idle", 128'(idle), 128'd1);

    // Saturating statistics: 33 slots absorb the first writes, the rest drop
    do_reset();
    out_ready = 1'b0;
    drive(8'hFF, 32'h55, 0);
    for (int c = 0; c < 8195; c++) tick();
    drive(8'h7F, 32'h55, 0);
    tick();
    chk("stats near-sat", 128'(drop_count), 128'hFFFE);
    chk("stats overflow", 128'(overflow), 128'd1);
    drive(8'h07, 32'h55, 0);
    tick();
    chk("stats clamp", 128'(drop_count), 128'hFFFF);
    clr_stats = 1'b1;
    drive(8'hFF, 32'h55, 0);
    tick();
    chk("clr drop_count", 128'(drop_count), 128'd0);
    chk("clr overflow", 128'(overflow), 128'd0);
    clr_stats = 1'b0;
    drive(8'h01, 32'h55, 0);
    tick();
    chk("post-clr drop_count", 128'(drop_count), 128'd1);
    chk("post-clr overflow", 128'(overflow), 128'd1);

    // Asynchronous reset while data is buffered
    drive(8'h00, 0, 0);
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(8'h02, 32'h20 + j, 0);
      tick();
    end
    drive(8'h00, 0, 0);
    tick();
    chk("rst pre out_valid", 128'(out_valid), 128'd1);
    chk("rst pre idle", 128'(idle), 128'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst async out_valid", 128'(out_valid), 128'd0);
    chk("rst async idle", 128'(idle), 128'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("rst no stale", 128'(stale), 128'd0);
    chk("rst idle after", 128'(idle), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
